// File: rtl/systolic_array_is_ctrl.sv
// Job sequencer for the input-stationary systolic array: preloads one input
// tile, streams N weight vectors, drains the skew pipeline and issues one
// psum buffer write per weight vector.
module systolic_array_is_ctrl #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int LATENCY      = ARRAY_WIDTH + ARRAY_HEIGHT - 1,
    parameter int COUNT_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_weights,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic                   input_rd_en,
    output logic [ADDR_WIDTH-1:0]  input_rd_addr,
    output logic                   input_en,
    output logic                   weight_rd_en,
    output logic [ADDR_WIDTH-1:0]  weight_rd_addr,
    output logic                   process_en,
    output logic                   psum_wr_en,
    output logic [ADDR_WIDTH-1:0]  psum_wr_addr
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FIN} state_t;

    localparam logic [COUNT_WIDTH-1:0] LOAD_LAST  = COUNT_WIDTH'(ARRAY_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] DRAIN_LAST = COUNT_WIDTH'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [COUNT_WIDTH-1:0] LEAD_LAST  = COUNT_WIDTH'(LATENCY - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [COUNT_WIDTH-1:0] r_cnt;        // reads/ticks issued in the current phase
    logic [COUNT_WIDTH-1:0] r_n;          // latched num_weights
    logic                   r_input_en;
    logic                   r_process_en;
    logic [COUNT_WIDTH-1:0] r_lead;       // process_en cycles seen, saturates at LATENCY-1
    logic [COUNT_WIDTH-1:0] r_wr_cnt;     // psum writes issued so far
    logic                   r_psum_wr_en;
    logic [ADDR_WIDTH-1:0]  r_psum_wr_addr;

    logic                   w_issue;
    logic                   w_drain_tick;
    logic                   w_flushed;
    logic                   w_lead_done;
    logic [COUNT_WIDTH-1:0] w_n_last;

    assign w_issue     = !stall;
    assign w_n_last    = r_n - COUNT_WIDTH'(1);
    assign w_lead_done = (r_lead == LEAD_LAST);
    // Job may only end once every registered strobe has left the pipeline.
    assign w_flushed   = !r_input_en && !r_process_en && !r_psum_wr_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; phase advances on the last issued read/tick of the phase
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_LOAD;
            S_LOAD:   if (w_issue && r_cnt == LOAD_LAST)
                          w_next_state = (r_n == '0) ? S_FIN : S_STREAM;
            S_STREAM: if (w_issue && r_cnt == w_n_last)
                          w_next_state = (LATENCY > 1) ? S_DRAIN : S_FIN;
            S_DRAIN:  if (w_issue && r_cnt == DRAIN_LAST) w_next_state = S_FIN;
            S_FIN:    if (w_flushed) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode: read strobes issue combinationally, gated by stall
    always_comb begin
        busy           = (r_state != S_IDLE);
        done           = (r_state == S_FIN) && w_flushed;
        input_rd_en    = (r_state == S_LOAD) && w_issue;
        input_rd_addr  = (r_state == S_LOAD) ? ADDR_WIDTH'(r_cnt) : '0;
        weight_rd_en   = (r_state == S_STREAM) && w_issue;
        weight_rd_addr = (r_state == S_STREAM) ? ADDR_WIDTH'(r_cnt) : '0;
        w_drain_tick   = (r_state == S_DRAIN) && w_issue;
        input_en       = r_input_en;
        process_en     = r_process_en;
        psum_wr_en     = r_psum_wr_en;
        psum_wr_addr   = r_psum_wr_addr;
    end

    // Phase counter and job-length capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_n   <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_n <= num_weights;
            if (w_next_state != r_state)    r_cnt <= '0;
            else if (w_issue && (r_state == S_LOAD || r_state == S_STREAM || r_state == S_DRAIN))
                r_cnt <= r_cnt + COUNT_WIDTH'(1);
        end
    end

    // Array enables trail the buffer read by one cycle to line up with read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_input_en   <= 1'b0;
            r_process_en <= 1'b0;
        end else begin
            r_input_en   <= input_rd_en;
            r_process_en <= weight_rd_en | w_drain_tick;
        end
    end

    // Psum writes: the first LATENCY-1 process cycles only fill the skew pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lead         <= '0;
            r_wr_cnt       <= '0;
            r_psum_wr_en   <= 1'b0;
            r_psum_wr_addr <= '0;
        end else begin
            r_psum_wr_en <= r_process_en && w_lead_done;
            if (r_state == S_IDLE) begin
                r_lead   <= '0;
                r_wr_cnt <= '0;
            end else if (r_process_en) begin
                if (!w_lead_done) r_lead <= r_lead + COUNT_WIDTH'(1);
                else begin
                    r_psum_wr_addr <= ADDR_WIDTH'(r_wr_cnt);
                    r_wr_cnt       <= r_wr_cnt + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_is_ctrl.sv
// Directed bench for systolic_array_is_ctrl at default parameters (LATENCY=7).
module tb_systolic_array_is_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_weights;
    logic        stall;
    logic        busy, done, input_rd_en, input_en, weight_rd_en, process_en, psum_wr_en;
    logic [9:0]  input_rd_addr, weight_rd_addr, psum_wr_addr;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_array_is_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_weights(num_weights), .stall(stall),
        .busy(busy), .done(done),
        .input_rd_en(input_rd_en), .input_rd_addr(input_rd_addr), .input_en(input_en),
        .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr), .process_en(process_en),
        .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations as bitmasks indexed by cycle (cycle 0 = start sampled).
    typedef struct {
        string       name;
        int          n;
        int          stall_cyc;
        logic [63:0] start_m;
        logic [63:0] in_rd, in_en, w_rd, proc_m, psum, done_m, busy_m;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, -1, 32'(busy), 0);
        chk({name, "_done"}, -1, 32'(done), 0);
        chk({name, "_strobes"}, -1,
            32'({input_rd_en, input_en, weight_rd_en, process_en, psum_wr_en}), 0);
        chk({name, "_addrs"}, -1, 32'({input_rd_addr, weight_rd_addr, psum_wr_addr}), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int ei = 0, ew = 0, ep = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            start       = v.start_m[c];
            stall       = (c == v.stall_cyc);
            num_weights = 16'(v.n);
            @(negedge clk);
            if (!v.busy_m[c]) begin ei = 0; ew = 0; ep = 0; end
            chk({v.name, "_busy"},   c, 32'(busy),         32'(v.busy_m[c]));
            chk({v.name, "_done"},   c, 32'(done),         32'(v.done_m[c]));
            chk({v.name, "_in_rd"},  c, 32'(input_rd_en),  32'(v.in_rd[c]));
            chk({v.name, "_in_en"},  c, 32'(input_en),     32'(v.in_en[c]));
            chk({v.name, "_w_rd"},   c, 32'(weight_rd_en), 32'(v.w_rd[c]));
            chk({v.name, "_proc"},   c, 32'(process_en),   32'(v.proc_m[c]));
            chk({v.name, "_psum"},   c, 32'(psum_wr_en),   32'(v.psum[c]));
            if (v.in_rd[c]) begin chk({v.name, "_in_addr"},   c, 32'(input_rd_addr),  ei); ei++; end
            if (v.w_rd[c])  begin chk({v.name, "_w_addr"},    c, 32'(weight_rd_addr), ew); ew++; end
            if (v.psum[c])  begin chk({v.name, "_psum_addr"}, c, 32'(psum_wr_addr),   ep); ep++; end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [63:0] one;
        int writes, dones, cyc;
        one = 64'd1;

        // N=3, no stall
        vecs[0] = '{"n3", 3, -1, one, rng(1,4), rng(2,5), rng(5,7), rng(6,14),
                    rng(13,15), rng(16,16), rng(1,16)};
        // N=3, stall in cycle 6
        vecs[1] = '{"n3_stall", 3, 6, one, rng(1,4), rng(2,5), rng(5,5) | rng(7,8),
                    rng(6,6) | rng(8,15), rng(14,16), rng(17,17), rng(1,17)};
        // N=0: input preload only
        vecs[2] = '{"n0", 0, -1, one, rng(1,4), rng(2,5), '0, '0, '0, rng(6,6), rng(1,6)};
        // N=2, stall in cycle 2 during preload
        vecs[3] = '{"n2_load_stall", 2, 2, one, rng(1,1) | rng(3,5), rng(2,2) | rng(4,6),
                    rng(6,7), rng(7,14), rng(14,15), rng(16,16), rng(1,16)};
        // N=3, start re-pulsed in cycles 3 and 10 (ignored), then back-to-back at 17
        vecs[4] = '{"b2b", 3, -1, one | (one << 3) | (one << 10) | (one << 17),
                    rng(1,4) | rng(18,21), rng(2,5) | rng(19,22), rng(5,7) | rng(22,24),
                    rng(6,14) | rng(23,31), rng(13,15) | rng(30,32), rng(16,16) | rng(33,33),
                    rng(1,16) | rng(18,33)};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; num_weights = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Asynchronous reset in cycle 9 of an N=3 job
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk); #1;
            start = (c == 0); num_weights = 16'd3;
        end
        chk("mid_pre_reset_proc", 9, 32'(process_en), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("mid_reset_no_done", -1, dones, 0);
        run_vec(vecs[0]);

        // N=1000 with ~25% random stall
        writes = 0; dones = 0; cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; num_weights = 16'd1000; stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (dones == 0 && cyc < 20000) begin
            stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (psum_wr_en) begin
                if (psum_wr_addr !== 10'(writes)) chk("long_addr", cyc, 32'(psum_wr_addr), 32'(10'(writes)));
                writes++;
            end
            if (done) dones++;
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        chk("long_timeout", cyc, 32'(cyc < 20000), 1);
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
            if (psum_wr_en) writes++;
        end
        chk("long_writes", -1, writes, 1000);
        chk("long_dones", -1, dones, 1);
        chk("long_idle", -1, 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
